// File: rtl/seg_display_mux.sv
// Time-multiplexed 7-segment driver: frame-coherent snapshot, leading-zero blanking, PWM dimming.
// Outputs registered (one clk after index/PWM/enable change); no flow control. Optional blink via SEG_BLINK_EN.
module seg_display_mux #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 10000,
    parameter int PWM_BITS     = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
`ifdef SEG_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  enable,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     cs,
    output logic                  frame_start
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    generate
        if (DIGITS < 1 || DIGITS > 8 || REFRESH_DIV < 2 || PWM_BITS < 1 || BLINK_FRAMES < 1) begin : g_bad_param
            $error("seg_display_mux: parameter out of range");
        end
    endgenerate

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;

    logic                tick;
    logic                wrap;
    logic                lit;
    logic                blanked;
    logic                blink_ok;
    logic                shown;
    logic [3:0]          cur_nib;
    logic [DIGITS-1:0]   upper_zero;
    logic                lz_acc;
    logic [DIGITS-1:0]   cs_on;
    logic [7:0]          seg_on;

    assign tick    = (presc == PRE_LAST);
    assign wrap    = tick && (idx == IDX_LAST);
    assign lit     = (&brightness) || (pwm_cnt < brightness);
    assign cur_nib = shadow_data[{idx, 2'b00} +: 4];

    // upper_zero[i]: shadow nibbles i..DIGITS-1 are all zero
    always_comb begin
        upper_zero = '0;
        lz_acc     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_acc        = lz_acc & (shadow_data[4*i +: 4] == 4'h0);
            upper_zero[i] = lz_acc;
        end
    end

    assign blanked = blank_lz && (idx != '0) && upper_zero[idx];

`ifdef SEG_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FC_W-1:0]   frame_cnt;
    logic              blink_off;
    logic [DIGITS-1:0] shadow_blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt    <= '0;
            blink_off    <= 1'b0;
            shadow_blink <= '0;
        end else if (wrap) begin
            shadow_blink <= blink_mask;
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_ok = !(blink_off && shadow_blink[idx]);
`else
    assign blink_ok = 1'b1;
`endif

    assign shown  = enable && lit && !blanked && blink_ok;
    assign cs_on  = shown ? (DIGITS'(1) << idx) : '0;
    assign seg_on = shown ? {shadow_dp[idx], font(cur_nib)} : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            frame_start <= 1'b0;
            cs          <= POL ? '1 : '0;
            seg         <= POL ? 8'hFF : 8'h00;
        end else begin
            pwm_cnt     <= pwm_cnt + 1'b1;
            presc       <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            frame_start <= wrap;
            if (wrap) begin
                shadow_data <= data;
                shadow_dp   <= dp_in;
            end
            // cs is rebuilt from a single index each clk, so it can never show two digits
            cs  <= POL ? ~cs_on : cs_on;
            seg <= POL ? ~seg_on : seg_on;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux (DIGITS=4, REFRESH_DIV=4, active-low outputs).
module tb_seg_display_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic        enable;
    logic [7:0]  seg;
    logic [3:0]  cs;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    logic [11:0] sb_q[$];
    logic        mon_en = 1'b0;
    logic [3:0]  prev_cs = 4'hF;
    logic [11:0] mon_exp;

    seg_display_mux #(
        .DIGITS(4), .REFRESH_DIV(4), .PWM_BITS(4), .ACTIVE_LOW(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank_lz(blank_lz),
        .brightness(brightness), .enable(enable), .seg(seg), .cs(cs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Monitor: each newly lit digit pops one expected {cs,seg}
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(~cs) > 1) begin
                errors++;
                $display("FAIL onehot: cs=%b has more than one active bit", cs);
            end
            if (cs != prev_cs && cs != 4'hF) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_digit: cs=%b seg=%h with empty scoreboard", cs, seg);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if ({cs, seg} !== mon_exp) begin
                        errors++;
                        $display("FAIL digit: cs=%b seg=%h, expected cs=%b seg=%h",
                                 cs, seg, mon_exp[11:8], mon_exp[7:0]);
                    end
                end
            end
        end
        prev_cs = cs;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) begin
            checks++;
            errors++;
            $display("FAIL fs_timeout: no frame_start within %0d clk", n);
        end
    endtask

    task automatic settle();
        wait_fs();
        wait_fs();
    endtask

    task automatic push4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        sb_q.push_back({4'b1110, s0});
        sb_q.push_back({4'b1101, s1});
        sb_q.push_back({4'b1011, s2});
        sb_q.push_back({4'b0111, s3});
    endtask

    task automatic end_window(input string name);
        mon_en = 1'b0;
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic count_win(input int n, output int act, output int fsn);
        act = 0;
        fsn = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cs != 4'hF) act++;
            if (frame_start) fsn++;
        end
    endtask

    int act, fsn, n;

    initial begin
        rst = 1'b1; data = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        brightness = 4'hF; enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cs", cs, 4'hF);
        check("reset_seg", seg, 8'hFF);
        rst = 1'b0;
        repeat (7) @(negedge clk);

        // Reset mid-scan takes effect without a clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_cs", cs, 4'hF);
        check("midreset_seg", seg, 8'hFF);
        check("midreset_fs", frame_start, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("release_cs", cs, 4'b1110);
        check("release_seg", seg, 8'hC0);

        // Basic scan of 1234: digit i shows nibble i
        data = 16'h1234;
        settle();
        mon_en = 1'b1;
        push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        repeat (32) @(negedge clk);
        end_window("basic_drained");

        wait_fs();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 100);
        check("fs_period", n, 16);
        @(negedge clk);
        check("fs_width", frame_start, 1'b0);

        // Mid-frame data change stays hidden until the next snapshot
        wait_fs();
        mon_en = 1'b1;
        push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        push4(8'hA1, 8'hC6, 8'h83, 8'h88);
        repeat (6) @(negedge clk);
        data = 16'hABCD;
        repeat (26) @(negedge clk);
        end_window("coherence_drained");

        // Leading-zero blanking; dp on digit 3 does not defeat it
        data = 16'h0042; dp_in = 4'b1000; blank_lz = 1'b1;
        settle();
        mon_en = 1'b1;
        sb_q.push_back({4'b1110, 8'hA4});
        sb_q.push_back({4'b1101, 8'h99});
        sb_q.push_back({4'b1110, 8'hA4});
        sb_q.push_back({4'b1101, 8'h99});
        repeat (32) @(negedge clk);
        end_window("blank_drained");

        blank_lz = 1'b0;
        settle();
        mon_en = 1'b1;
        push4(8'hA4, 8'h99, 8'hC0, 8'h40);
        repeat (16) @(negedge clk);
        end_window("noblank_drained");

        // Brightness / enable
        data = 16'hABCD; dp_in = 4'h0;
        brightness = 4'h0;
        repeat (2) @(negedge clk);
        count_win(32, act, fsn);
        check("bright0_active", act, 0);
        check("bright0_seg", seg, 8'hFF);

        brightness = 4'h8;
        repeat (2) @(negedge clk);
        count_win(16, act, fsn);
        check("bright8_active16", act, 8);
        count_win(32, act, fsn);
        check("bright8_active32", act, 16);

        brightness = 4'h1;
        repeat (2) @(negedge clk);
        count_win(16, act, fsn);
        check("bright1_active", act, 1);

        brightness = 4'hF;
        repeat (2) @(negedge clk);
        count_win(16, act, fsn);
        check("brightF_active", act, 16);

        enable = 1'b0;
        repeat (2) @(negedge clk);
        count_win(32, act, fsn);
        check("disabled_active", act, 0);
        check("disabled_fs", fsn, 2);
        check("disabled_seg", seg, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
